// File: rtl/am2910_next_addr.sv
// Am2910 next-address stage: decodes the instruction, holds uPC and R, drives the LIFO stack controls.
// Latency: y and stack controls are combinational; uPC and R update on the rising edge of i_clk.
// No backpressure: the stack ignores push-when-full and pop-when-empty, so this block asserts them freely.
module am2910_next_addr #(
  parameter int W = 12
) (
  input  logic         i_clk,
  input  logic         i_clear,
  input  logic [3:0]   i_i,
  input  logic [W-1:0] i_d,
  input  logic         i_ccen,
  input  logic         i_cc,
  input  logic         i_ci,
  input  logic [W-1:0] i_stk_top,
  output logic [W-1:0] o_y,
  output logic [W-1:0] o_stk_di,
  output logic         o_stk_push,
  output logic         o_stk_pop,
  output logic         o_stk_clear,
  output logic         o_r_zero,
  output logic         o_pl_n,
  output logic         o_map_n,
  output logic         o_vect_n
);

  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CJS  = 4'd1;
  localparam logic [3:0] OP_JMAP = 4'd2;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_JSRP = 4'd5;
  localparam logic [3:0] OP_CJV  = 4'd6;
  localparam logic [3:0] OP_JRP  = 4'd7;
  localparam logic [3:0] OP_RFCT = 4'd8;
  localparam logic [3:0] OP_RPCT = 4'd9;
  localparam logic [3:0] OP_CRTN = 4'd10;
  localparam logic [3:0] OP_CJPP = 4'd11;
  localparam logic [3:0] OP_LDCT = 4'd12;
  localparam logic [3:0] OP_LOOP = 4'd13;
  localparam logic [3:0] OP_CONT = 4'd14;
  localparam logic [3:0] OP_TWB  = 4'd15;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_upc;
  logic [W-1:0] r_cnt;

  logic         w_pass;
  logic         w_zero;
  logic [W-1:0] w_y;
  logic         w_push;
  logic         w_pop;
  logic         w_sclr;
  logic         w_load;
  logic         w_dec;
  logic         w_pl_n;
  logic         w_map_n;
  logic         w_vect_n;

  assign w_pass = ~i_ccen | i_cc;
  assign w_zero = (r_cnt == '0);

  // Instruction decode: next address, stack action and counter action.
  always_comb begin
    w_y      = r_upc;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_sclr   = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_pl_n   = 1'b0;
    w_map_n  = 1'b1;
    w_vect_n = 1'b1;
    case (i_i)
      OP_JZ: begin
        w_y    = '0;
        w_sclr = 1'b1;
      end
      OP_CJS: begin
        if (w_pass) begin
          w_y    = i_d;
          w_push = 1'b1;
        end
      end
      OP_JMAP: begin
        w_y     = i_d;
        w_pl_n  = 1'b1;
        w_map_n = 1'b0;
      end
      OP_CJP: begin
        if (w_pass) w_y = i_d;
      end
      OP_PUSH: begin
        w_push = 1'b1;
        w_load = w_pass;
      end
      OP_JSRP: begin
        w_y    = w_pass ? i_d : r_cnt;
        w_push = 1'b1;
      end
      OP_CJV: begin
        if (w_pass) w_y = i_d;
        w_pl_n   = 1'b1;
        w_vect_n = 1'b0;
      end
      OP_JRP: begin
        w_y = w_pass ? i_d : r_cnt;
      end
      OP_RFCT: begin
        if (!w_zero) begin
          w_y   = i_stk_top;
          w_dec = 1'b1;
        end else begin
          w_pop = 1'b1;
        end
      end
      OP_RPCT: begin
        if (!w_zero) begin
          w_y   = i_d;
          w_dec = 1'b1;
        end
      end
      OP_CRTN: begin
        if (w_pass) begin
          w_y   = i_stk_top;
          w_pop = 1'b1;
        end
      end
      OP_CJPP: begin
        if (w_pass) begin
          w_y   = i_d;
          w_pop = 1'b1;
        end
      end
      OP_LDCT: begin
        w_load = 1'b1;
      end
      OP_LOOP: begin
        if (w_pass) w_pop = 1'b1;
        else        w_y   = i_stk_top;
      end
      OP_CONT: begin
        w_y = r_upc;
      end
      OP_TWB: begin
        if (!w_zero) begin
          w_dec = 1'b1;
          if (w_pass) w_pop = 1'b1;
          else        w_y   = i_stk_top;
        end else begin
          w_pop = 1'b1;
          if (!w_pass) w_y = i_d;
        end
      end
    endcase
  end

  // Clear overrides every output immediately, independent of the instruction.
  assign o_y         = i_clear ? '0   : w_y;
  assign o_stk_di    = i_clear ? '0   : r_upc;
  assign o_stk_push  = i_clear ? 1'b0 : w_push;
  assign o_stk_pop   = i_clear ? 1'b0 : w_pop;
  assign o_stk_clear = i_clear ? 1'b1 : w_sclr;
  assign o_r_zero    = i_clear ? 1'b1 : w_zero;
  assign o_pl_n      = i_clear ? 1'b0 : w_pl_n;
  assign o_map_n     = i_clear ? 1'b1 : w_map_n;
  assign o_vect_n    = i_clear ? 1'b1 : w_vect_n;

  // Microprogram counter: next address plus carry-in, wrapping at 2^W.
  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) r_upc <= '0;
    else         r_upc <= w_y + {{(W-1){1'b0}}, i_ci};
  end

  // Register/counter: load has priority; decrement only issued when R is non-zero.
  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear)     r_cnt <= '0;
    else if (w_load) r_cnt <= i_d;
    else if (w_dec)  r_cnt <= r_cnt - ONE;
  end

endmodule

// File: tb/tb_am2910_next_addr.sv
// Directed bench for am2910_next_addr: linear instruction sequence with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
// Stack top is driven directly by the bench to stand in for the LIFO.
module tb_am2910_next_addr;

  logic        clk;
  logic        clear;
  logic [3:0]  i;
  logic [11:0] d;
  logic        ccen;
  logic        cc;
  logic        ci;
  logic [11:0] stk_top;
  logic [11:0] y;
  logic [11:0] stk_di;
  logic        stk_push;
  logic        stk_pop;
  logic        stk_clear;
  logic        r_zero;
  logic        pl_n;
  logic        map_n;
  logic        vect_n;

  int n_checks = 0;
  int n_errors = 0;

  am2910_next_addr #(.W(12)) dut (
    .i_clk       (clk),
    .i_clear     (clear),
    .i_i         (i),
    .i_d         (d),
    .i_ccen      (ccen),
    .i_cc        (cc),
    .i_ci        (ci),
    .i_stk_top   (stk_top),
    .o_y         (y),
    .o_stk_di    (stk_di),
    .o_stk_push  (stk_push),
    .o_stk_pop   (stk_pop),
    .o_stk_clear (stk_clear),
    .o_r_zero    (r_zero),
    .o_pl_n      (pl_n),
    .o_map_n     (map_n),
    .o_vect_n    (vect_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [3:0] ii, input logic [11:0] dd, input logic en,
                       input logic c, input logic cin, input logic [11:0] top);
    i = ii; d = dd; ccen = en; cc = c; ci = cin; stk_top = top;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with an instruction that would otherwise push and branch.
    clear = 1'b1;
    apply(4'd1, 12'h123, 1'b0, 1'b0, 1'b1, 12'h000);
    chk("rst_y", y, 12'h000);
    chk("rst_push", {11'd0, stk_push}, 12'd0);
    chk("rst_pop", {11'd0, stk_pop}, 12'd0);
    chk("rst_sclr", {11'd0, stk_clear}, 12'd1);
    chk("rst_di", stk_di, 12'h000);
    chk("rst_rzero", {11'd0, r_zero}, 12'd1);
    chk("rst_en", {9'd0, pl_n, map_n, vect_n}, 12'b011);
    clear = 1'b0;

    // CONT with ci=1 counts up from 0.
    for (int k = 0; k < 4; k++) begin
      apply(4'd14, 12'h000, 1'b1, 1'b0, 1'b1, 12'h000);
      chk("cont_y", y, 12'(k));
      chk("cont_push", {11'd0, stk_push}, 12'd0);
      chk("cont_rzero", {11'd0, r_zero}, 12'd1);
      tick();
    end
    apply(4'd14, 12'h000, 1'b1, 1'b0, 1'b1, 12'h000);
    chk("cont_y4", y, 12'h004);
    tick();                                           // uPC = 5

    // Subroutine call and return.
    apply(4'd1, 12'h100, 1'b1, 1'b1, 1'b1, 12'h000);
    chk("cjs_y", y, 12'h100);
    chk("cjs_push", {11'd0, stk_push}, 12'd1);
    chk("cjs_di", stk_di, 12'h005);
    tick();                                           // uPC = 0x101
    apply(4'd10, 12'h000, 1'b1, 1'b1, 1'b1, 12'h005);
    chk("crtn_y", y, 12'h005);
    chk("crtn_pop", {11'd0, stk_pop}, 12'd1);
    chk("crtn_push", {11'd0, stk_push}, 12'd0);
    tick();                                           // uPC = 6
    apply(4'd14, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000);
    chk("ret_upc", y, 12'h006);
    chk("ret_di", stk_di, 12'h006);
    tick();                                           // wait state, uPC holds
    apply(4'd14, 12'h000, 1'b1, 1'b0, 1'b1, 12'h000);
    chk("wait_y", y, 12'h006);
    tick();                                           // uPC = 7

    // LDCT then RPCT loop.
    apply(4'd12, 12'h003, 1'b1, 1'b0, 1'b1, 12'h000);
    chk("ldct_y", y, 12'h007);
    tick();                                           // R = 3, uPC = 8
    for (int k = 0; k < 3; k++) begin
      apply(4'd9, 12'h040, 1'b1, 1'b0, 1'b1, 12'h000);
      chk("rpct_y", y, 12'h040);
      chk("rpct_rzero", {11'd0, r_zero}, 12'd0);
      tick();                                         // uPC = 0x41
    end
    apply(4'd9, 12'h040, 1'b1, 1'b0, 1'b1, 12'h000);
    chk("rpct_end_y", y, 12'h041);
    chk("rpct_end_rzero", {11'd0, r_zero}, 12'd1);
    tick();                                           // uPC = 0x42

    // Conditional jump, map and vector.
    apply(4'd3, 12'h200, 1'b1, 1'b0, 1'b1, 12'h000);
    chk("cjp_fail_y", y, 12'h042);
    chk("cjp_fail_pl", {11'd0, pl_n}, 12'd0);
    tick();                                           // uPC = 0x43
    apply(4'd3, 12'h200, 1'b0, 1'b0, 1'b1, 12'h000);
    chk("cjp_force_y", y, 12'h200);
    tick();                                           // uPC = 0x201
    apply(4'd2, 12'h0AB, 1'b1, 1'b0, 1'b1, 12'h000);
    chk("jmap_y", y, 12'h0AB);
    chk("jmap_en", {9'd0, pl_n, map_n, vect_n}, 12'b101);
    tick();                                           // uPC = 0xAC
    apply(4'd6, 12'h0CD, 1'b1, 1'b1, 1'b1, 12'h000);
    chk("cjv_y", y, 12'h0CD);
    chk("cjv_en", {9'd0, pl_n, map_n, vect_n}, 12'b110);
    tick();                                           // uPC = 0xCE

    // JRP fail selects R (currently 0).
    apply(4'd7, 12'h3AA, 1'b1, 1'b0, 1'b1, 12'h000);
    chk("jrp_fail_y", y, 12'h000);
    tick();                                           // uPC = 1

    // Three-way branch.
    apply(4'd12, 12'h002, 1'b1, 1'b0, 1'b1, 12'h000);
    chk("ldct2_y", y, 12'h001);
    tick();                                           // R = 2, uPC = 2
    for (int k = 0; k < 2; k++) begin
      apply(4'd15, 12'h300, 1'b1, 1'b0, 1'b1, 12'h020);
      chk("twb_loop_y", y, 12'h020);
      chk("twb_loop_pop", {11'd0, stk_pop}, 12'd0);
      tick();                                         // uPC = 0x21
    end
    apply(4'd15, 12'h300, 1'b1, 1'b0, 1'b1, 12'h020);
    chk("twb_exit_y", y, 12'h300);
    chk("twb_exit_pop", {11'd0, stk_pop}, 12'd1);
    tick();                                           // uPC = 0x301

    // JZ resets the address and clears the stack.
    apply(4'd0, 12'h555, 1'b1, 1'b0, 1'b1, 12'h000);
    chk("jz_y", y, 12'h000);
    chk("jz_sclr", {11'd0, stk_clear}, 12'd1);
    tick();                                           // uPC = 1

    // Clear asserted in the middle of an RFCT loop.
    apply(4'd12, 12'h005, 1'b1, 1'b0, 1'b1, 12'h000);
    tick();                                           // R = 5, uPC = 2
    apply(4'd8, 12'h000, 1'b1, 1'b0, 1'b1, 12'h050);
    chk("rfct_y", y, 12'h050);
    tick();                                           // R = 4, uPC = 0x51
    apply(4'd8, 12'h000, 1'b1, 1'b0, 1'b1, 12'h050);
    chk("rfct_y2", y, 12'h050);
    clear = 1'b1;
    #1;
    chk("mid_clr_y", y, 12'h000);
    chk("mid_clr_sclr", {11'd0, stk_clear}, 12'd1);
    chk("mid_clr_rzero", {11'd0, r_zero}, 12'd1);
    #1;
    clear = 1'b0;
    apply(4'd8, 12'h000, 1'b1, 1'b0, 1'b1, 12'h050);
    chk("post_clr_y", y, 12'h000);
    chk("post_clr_pop", {11'd0, stk_pop}, 12'd1);
    chk("post_clr_rzero", {11'd0, r_zero}, 12'd1);
    tick();                                           // uPC = 1

    // uPC wrap at 0xFFF.
    apply(4'd3, 12'hFFE, 1'b0, 1'b0, 1'b1, 12'h000);
    tick();                                           // uPC = 0xFFF
    apply(4'd14, 12'h000, 1'b1, 1'b0, 1'b1, 12'h000);
    chk("wrap_pre", y, 12'hFFF);
    tick();                                           // uPC = 0x000
    apply(4'd14, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000);
    chk("wrap_post", y, 12'h000);
    chk("wrap_di", stk_di, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
